// File: rtl/bus_fabric.sv
// CPU-side system bus fabric: splits the CPU address space into 2**REGION_BITS
// equal regions, issues per-region select and write strobes, inserts programmable
// wait states through cpu_rdy, and blocks and counts writes to read-only or
// unmapped regions. Read data comes back through a mux steered by the select
// registered on the last ready cycle. Unmapped regions return OPEN_BUS.
//
// Handshake: an access is complete in the cycle where cpu_rdy=1. While cpu_rdy=0
// the CPU holds cpu_ab/cpu_we/cpu_do stable, so the live address is decoded in
// every cycle. The write strobe fires only in the completing cycle. Read data is
// valid on cpu_di in the cycle after the completing cycle.
module bus_fabric #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int REGION_BITS = 2,
  parameter logic [4*(2**REGION_BITS)-1:0] WAIT_STATES = 16'h0000,
  parameter logic [(2**REGION_BITS)-1:0]   RO_MASK     = 4'b1100,
  parameter logic [(2**REGION_BITS)-1:0]   MAP_MASK    = 4'b1111,
  parameter logic [DATA_W-1:0]             OPEN_BUS    = 8'hFF
) (
  input  logic                                  clk_pix,
  input  logic                                  rst_pix,
  input  logic [ADDR_W-1:0]                     cpu_ab,
  input  logic [DATA_W-1:0]                     cpu_do,
  input  logic                                  cpu_we,
  output logic [DATA_W-1:0]                     cpu_di,
  output logic                                  cpu_rdy,
  output logic [(2**REGION_BITS)-1:0]           slv_sel,
  output logic [(2**REGION_BITS)-1:0]           slv_we,
  output logic [ADDR_W-REGION_BITS-1:0]         slv_addr,
  output logic [DATA_W-1:0]                     slv_wdata,
  input  logic [(2**REGION_BITS)*DATA_W-1:0]    slv_rdata,
  output logic                                  wr_fault,
  output logic [7:0]                            fault_count
);

  localparam int NUM_REGIONS = 2**REGION_BITS;
  localparam int OFF_W       = ADDR_W - REGION_BITS;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [REGION_BITS-1:0]  sel_q;
  logic                    map_q;

  logic [REGION_BITS-1:0]  region;
  logic [3:0]              ws;
  logic                    region_ro;
  logic                    region_mapped;
  logic [NUM_REGIONS-1:0]  region_onehot;
  logic                    rdy_raw;
  logic                    write_done;
  logic                    write_blocked;

  // Address decode. The region comes from the top address bits only, so
  // cpu_rdy depends on cpu_ab and never the other way round.
  assign region        = cpu_ab[ADDR_W-1 -: REGION_BITS];
  assign ws            = WAIT_STATES[4*region +: 4];
  assign region_ro     = RO_MASK[region];
  assign region_mapped = MAP_MASK[region];
  assign region_onehot = {{(NUM_REGIONS-1){1'b0}}, 1'b1} << region;

  // In IDLE a 0-wait region completes at once. In WAIT the stored count
  // decides, and the wait state is not decoded again.
  assign rdy_raw       = (state == S_IDLE) ? (ws == 4'd0) : (cnt == 4'd0);
  assign write_done    = ~rst_pix & cpu_we & rdy_raw;
  assign write_blocked = write_done & (region_ro | ~region_mapped);

  // During reset the CPU sees ready and the slaves see neither select nor strobe.
  assign cpu_rdy   = rst_pix | rdy_raw;
  assign slv_sel   = rst_pix ? '0 : region_onehot;
  assign slv_we    = (write_done & ~region_ro & region_mapped) ? region_onehot : '0;
  assign slv_addr  = cpu_ab[OFF_W-1:0];
  assign slv_wdata = cpu_do;
  assign cpu_di    = map_q ? slv_rdata[DATA_W*sel_q +: DATA_W] : OPEN_BUS;

  // Wait-state sequencer: loads ws-1 on entry and counts down to the ready cycle.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ws != 4'd0) begin
            state <= S_WAIT;
            cnt   <= ws - 4'd1;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Capture the read-return steering on each completing cycle. It holds across stalls.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      sel_q <= '0;
      map_q <= 1'b1;
    end else if (rdy_raw) begin
      sel_q <= region;
      map_q <= region_mapped;
    end
  end

  // Blocked-write pulse and saturating fault counter.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      wr_fault    <= 1'b0;
      fault_count <= 8'd0;
    end else begin
      wr_fault <= write_blocked;
      if (write_blocked && fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
    end
  end

endmodule
